floating_point_div: RTL
=======================

Name: floating_point_div

Overview:
- Iterative IEEE-754 single-precision divider producing one quotient bit per cycle, with a start/done handshake.
- Inverse companion to the sequential floating-point multiplier. Sits beside it under the floating-point ALU and is selected there for the divide operation.
- Fixed latency for every operand class, so ALU sequencing and verification stay simple.
- Subnormals are flushed to zero; rounding is round-to-nearest-even.

Parameters:
- EXP_W, 8, exponent field width.
- FRAC_W, 23, fraction field width. Operand width W = 1+EXP_W+FRAC_W. Only 8/23 is verified.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  W  dividend, binary32
- b  input  W  divisor, binary32
- result  output  W  quotient; held until the next completion
- done  output  1  one-cycle pulse when result and flags are valid
- busy  output  1  high from the cycle after start is accepted until done
- overflow  output  1  finite result too large; result is ±inf
- underflow  output  1  nonzero result below the normal range; flushed to ±0
- div_by_zero  output  1  finite nonzero / zero
- invalid  output  1  NaN operand, 0/0 or inf/inf

Behaviour:
- Reset: one clock; reset is synchronous and active-high, named rst on clock clk. All outputs and internal registers go to 0 and state goes to IDLE. Reset mid-operation aborts the operation with no done pulse.
- States: IDLE -> PREP -> DIVIDE -> ROUND -> IDLE.
- IDLE:
  - done is low except the single cycle after ROUND.
  - When start=1, a and b are registered; go to PREP.
  - start in any other state is ignored. Operands may change after acceptance.
- PREP (1 cycle):
  - Unpack operands. A field with exp=0 is treated as ±0 (FTZ).
  - Mantissas get the hidden 1 prepended (24 bits).
  - Exponent e = ea - eb + 127, held as a signed EXP_W+3 bit value.
  - sign = sa^sb.
  - Classify specials; the special outcome overrides the datapath in ROUND.
  - Clear the iteration counter.
- DIVIDE (FRAC_W+3 = 26 cycles):
  - Restoring division: compare remainder against divisor mantissa, subtract if ≥, shift the quotient bit in, shift the remainder left.
  - Leave when the counter reaches 25.
- ROUND (1 cycle):
  - If q[25]=1: mant=q[25:2], guard=q[1], sticky=q[0]|(rem!=0).
  - Else: mant=q[24:1], guard=q[0], sticky=(rem!=0), e=e-1.
  - RNE: increment mant if guard & (sticky | mant[0]). A mantissa carry-out shifts right and increments e.
  - If e≥255: ±inf with overflow=1.
  - If e≤0: ±0 with underflow=1.
  - Register result and flags; done=1 for one cycle; return to IDLE.
- Latency: done is visible exactly 28 cycles after the edge that samples start, i.e. FRAC_W+5.
- Back-to-back: start may be asserted during the done cycle and is accepted at the next edge. Throughput is one operation per 29 cycles.
- Specials (same latency; the datapath result is discarded):
  - Either operand NaN, 0/0, or inf/inf -> 0x7FC00000, invalid=1.
  - finite nonzero / 0 -> ±inf, div_by_zero=1.
  - inf / finite -> ±inf, no flag.
  - 0 / nonzero, or finite / inf -> ±0, no flag.
  - Exactly one flag is set at most. All flags clear on the next accepted start.

Test Plan:
- 6.0/2.0: a=0x40C00000, b=0x40000000, start at edge 0 -> done high after edge 28 only; result=0x40400000; all flags 0; busy high during edges 1..28.
- 1.0/3.0: 0x3F800000/0x40400000 -> 0x3EAAAAAB (round up). Then -7.5/2.5: 0xC0F00000/0x40200000 -> 0xC0400000.
- Specials:
  - 0x3F800000/0x00000000 -> 0x7F800000, div_by_zero=1.
  - 0/0 -> 0x7FC00000, invalid=1.
  - 0x7F800000/0x7F800000 -> 0x7FC00000, invalid=1.
  - 0x00400000 (subnormal)/0x3F800000 -> 0x00000000, no flag.
- Range limits:
  - 0x7F000000/0x3E800000 -> 0x7F800000, overflow=1.
  - 0x00800000/0x40000000 -> 0x00000000, underflow=1.
- start held high for 60 cycles with different operands per op -> first done after edge 28, second after edge 57. Starts during busy are ignored; exactly two done pulses.
- rst asserted for one cycle at edge 10 of an operation -> no done; all outputs 0, busy 0. A new start then completes normally in 28 cycles.

Source files
------------

// File: rtl/floating_point_div.sv
// Iterative IEEE-754 single-precision divider: restoring division, one quotient
// bit per cycle, flush-to-zero for subnormals, round-to-nearest-even.
// Every operand class takes the same number of cycles (start edge + 28).
module floating_point_div #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [EXP_W+FRAC_W:0]   a,
  input  logic [EXP_W+FRAC_W:0]   b,
  output logic [EXP_W+FRAC_W:0]   result,
  output logic                    done,
  output logic                    busy,
  output logic                    overflow,
  output logic                    underflow,
  output logic                    div_by_zero,
  output logic                    invalid
);

  localparam int W     = 1 + EXP_W + FRAC_W;
  localparam int M_W   = FRAC_W + 1;          // mantissa with hidden bit
  localparam int Q_W   = FRAC_W + 3;          // quotient bits: mantissa + guard + one spare
  localparam int E_W   = EXP_W + 3;           // signed working exponent
  localparam int CNT_W = $clog2(Q_W + 1);
  localparam logic signed [E_W-1:0] BIAS_S = E_W'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [E_W-1:0] EMAX_S = E_W'((1 << EXP_W) - 1);
  localparam logic signed [E_W-1:0] ONE_S  = E_W'(1);
  localparam logic signed [E_W-1:0] ZERO_S = '0;
  localparam logic [CNT_W-1:0]      LAST   = CNT_W'(Q_W - 1);

  typedef enum logic [1:0] {IDLE, PREP, DIVIDE, ROUND} state_t;
  typedef enum logic [2:0] {SP_NONE, SP_NAN, SP_DZ, SP_INF, SP_ZERO} special_t;

  state_t   state, state_nxt;
  special_t special_r;

  logic [W-1:0]            a_r, b_r;
  logic                    sign_r;
  logic signed [E_W-1:0]   e_r;
  logic [M_W-1:0]          div_r;
  logic [M_W:0]            rem_r;
  logic [Q_W-1:0]          q_r;
  logic [CNT_W-1:0]        cnt_r;

  // Operand fields, read while in PREP
  logic [EXP_W-1:0]  ea, eb;
  logic [FRAC_W-1:0] fa, fb;
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  // Rounding path signals, consumed in ROUND
  logic [M_W-1:0]        mant_pre, mant_fin;
  logic [M_W:0]          mant_inc;
  logic                  guard, sticky;
  logic signed [E_W-1:0] e_adj, e_fin;
  logic [M_W:0]          rem_diff;

  // Round-to-nearest-even increment; the extra top bit catches mantissa carry-out
  function automatic logic [M_W:0] rne_inc(input logic [M_W-1:0] m, input logic g, input logic s);
    return {1'b0, m} + {{M_W{1'b0}}, g & (s | m[0])};
  endfunction

  assign ea     = a_r[W-2:FRAC_W];
  assign eb     = b_r[W-2:FRAC_W];
  assign fa     = a_r[FRAC_W-1:0];
  assign fb     = b_r[FRAC_W-1:0];
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == '1) && (fa == '0);
  assign b_inf  = (eb == '1) && (fb == '0);
  assign a_nan  = (ea == '1) && (fa != '0);
  assign b_nan  = (eb == '1) && (fb != '0);
  assign rem_diff = rem_r - {1'b0, div_r};
  assign busy   = (state != IDLE);

  // Normalise the raw quotient, round it and adjust the exponent
  always_comb begin
    mant_pre = q_r[Q_W-1] ? q_r[Q_W-1:2] : q_r[Q_W-2:1];
    guard    = q_r[Q_W-1] ? q_r[1] : q_r[0];
    sticky   = q_r[Q_W-1] ? (q_r[0] | (rem_r != '0)) : (rem_r != '0);
    e_adj    = q_r[Q_W-1] ? e_r : e_r - ONE_S;
    mant_inc = rne_inc(mant_pre, guard, sticky);
    mant_fin = mant_inc[M_W-1:0];
    e_fin    = e_adj;
    if (mant_inc[M_W]) begin
      mant_fin = mant_inc[M_W:1];
      e_fin    = e_adj + ONE_S;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: fixed sequence, start only honoured in IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = PREP;
      PREP:    state_nxt = DIVIDE;
      DIVIDE:  if (cnt_r == LAST) state_nxt = ROUND;
      ROUND:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath, special-case classification and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r <= '0; b_r <= '0; sign_r <= 1'b0; e_r <= '0;
      div_r <= '0; rem_r <= '0; q_r <= '0; cnt_r <= '0;
      special_r <= SP_NONE;
      result <= '0; done <= 1'b0;
      overflow <= 1'b0; underflow <= 1'b0; div_by_zero <= 1'b0; invalid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_r <= a;
            b_r <= b;
            overflow <= 1'b0; underflow <= 1'b0; div_by_zero <= 1'b0; invalid <= 1'b0;
          end
        end
        PREP: begin
          sign_r <= a_r[W-1] ^ b_r[W-1];
          e_r    <= $signed({3'b000, ea}) - $signed({3'b000, eb}) + BIAS_S;
          rem_r  <= {2'b01, fa};
          div_r  <= {1'b1, fb};
          q_r    <= '0;
          cnt_r  <= '0;
          if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) special_r <= SP_NAN;
          else if (a_inf)                                                special_r <= SP_INF;
          else if (b_zero)                                               special_r <= SP_DZ;
          else if (a_zero || b_inf)                                      special_r <= SP_ZERO;
          else                                                           special_r <= SP_NONE;
        end
        DIVIDE: begin
          // Remainder stays below the divisor after each step, so the shift never loses a bit
          if (rem_r >= {1'b0, div_r}) begin
            rem_r <= {rem_diff[M_W-1:0], 1'b0};
            q_r   <= {q_r[Q_W-2:0], 1'b1};
          end else begin
            rem_r <= {rem_r[M_W-1:0], 1'b0};
            q_r   <= {q_r[Q_W-2:0], 1'b0};
          end
          cnt_r <= cnt_r + 1'b1;
        end
        ROUND: begin
          done <= 1'b1;
          case (special_r)
            SP_NAN: begin
              result  <= {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
              invalid <= 1'b1;
            end
            SP_DZ: begin
              result      <= {sign_r, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
              div_by_zero <= 1'b1;
            end
            SP_INF:  result <= {sign_r, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            SP_ZERO: result <= {sign_r, {(W-1){1'b0}}};
            default: begin
              if (e_fin >= EMAX_S) begin
                result   <= {sign_r, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                overflow <= 1'b1;
              end else if (e_fin <= ZERO_S) begin
                result    <= {sign_r, {(W-1){1'b0}}};
                underflow <= 1'b1;
              end else begin
                result <= {sign_r, e_fin[EXP_W-1:0], mant_fin[FRAC_W-1:0]};
              end
            end
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule
